// File: rtl/ew_pkg.sv
// Shared types and helpers for the threat response scheduler.
// Threat identifiers follow the bit order of the signal monitor's threat vector.
package ew_pkg;

    localparam int THREAT_W = 8;
    localparam int ID_W     = 3;

    typedef enum logic [ID_W-1:0] {
        BURST_JAM     = 3'd0,
        SIGNAL_DROP   = 3'd1,
        SPOOF         = 3'd2,
        BLANKING      = 3'd3,
        RAMP_JAM      = 3'd4,
        ENTROPY_NOISE = 3'd5,
        RANDOM_NOISE  = 3'd6,
        ALL_ZERO      = 3'd7
    } threat_id_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } sched_state_t;

    function automatic logic [3:0] popcount8(input logic [THREAT_W-1:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < THREAT_W; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the lowest requesting index at or
// above the pointer, wrapping from 7 back to 0.
module rr_arbiter
    import ew_pkg::*;
(
    input  logic [THREAT_W-1:0] req,
    input  logic [ID_W-1:0]     ptr,
    output logic [THREAT_W-1:0] grant,
    output logic [ID_W-1:0]     idx,
    output logic                any_req
);

    logic [ID_W-1:0] cand;

    // Scan offsets from farthest to nearest so the nearest request wins.
    always_comb begin
        idx     = 3'd0;
        cand    = 3'd0;
        any_req = |req;
        for (int k = THREAT_W - 1; k >= 0; k--) begin
            cand = ptr + 3'(k);
            if (req[cand]) begin
                idx = cand;
            end else begin
                idx = idx;
            end
        end
        if (any_req) begin
            grant = 8'd1 << idx;
        end else begin
            grant = 8'd0;
        end
    end

endmodule

// File: rtl/threat_response_scheduler.sv
// Coalesces threat events, arbitrates round-robin among pending types and issues
// one countermeasure command at a time, with per-type cooldown after service.
module threat_response_scheduler
    import ew_pkg::*;
#(
    parameter int HOLDOFF_CYCLES = 16,
    parameter int CNT_W          = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [THREAT_W-1:0] threat_vector,
    input  logic                enable,
    input  logic [THREAT_W-1:0] mask,
    output logic                cm_valid,
    input  logic                cm_ready,
    output logic [ID_W-1:0]     cm_id,
    output logic [CNT_W-1:0]    cm_count,
    output logic [THREAT_W-1:0] pending,
    output logic                busy,
    output logic [15:0]         suppressed_cnt
);

    localparam int CD_RAW = $clog2(HOLDOFF_CYCLES + 1);
    localparam int CD_W   = (CD_RAW < 1) ? 1 : CD_RAW;
    localparam logic [CD_W-1:0]  CD_LOAD = CD_W'(HOLDOFF_CYCLES);
    localparam logic [CNT_W-1:0] OCC_MAX = {CNT_W{1'b1}};

    sched_state_t        state_r;
    logic                cm_valid_r;
    logic                busy_r;
    logic [ID_W-1:0]     cm_id_r;
    logic [CNT_W-1:0]    cm_count_r;
    logic [ID_W-1:0]     rr_ptr_r;
    logic [THREAT_W-1:0] pending_r;
    logic [CNT_W-1:0]    occ_r      [THREAT_W];
    logic [CD_W-1:0]     cooldown_r [THREAT_W];
    logic [15:0]         suppressed_r;

    logic [THREAT_W-1:0] cool_s;
    logic [THREAT_W-1:0] live_s;
    logic [THREAT_W-1:0] accept_s;
    logic [THREAT_W-1:0] suppress_s;
    logic [THREAT_W-1:0] arb_req_s;
    logic [THREAT_W-1:0] grant_s;
    logic [ID_W-1:0]     sel_s;
    logic                any_s;
    logic                take_s;
    logic                handshake_s;
    logic [16:0]         sup_sum_s;

    rr_arbiter u_arb (
        .req     (arb_req_s),
        .ptr     (rr_ptr_r),
        .grant   (grant_s),
        .idx     (sel_s),
        .any_req (any_s)
    );

    // Per-type event qualification and FSM transition strobes.
    always_comb begin
        cool_s = 8'h00;
        for (int i = 0; i < THREAT_W; i++) begin
            if (cooldown_r[i] != CD_W'(0)) begin
                cool_s[i] = 1'b1;
            end else begin
                cool_s[i] = 1'b0;
            end
        end
        live_s      = threat_vector & mask & {THREAT_W{enable}};
        accept_s    = live_s & ~cool_s;
        suppress_s  = live_s & cool_s;
        arb_req_s   = pending_r & mask & {THREAT_W{enable}};
        take_s      = (state_r == IDLE) && any_s;
        handshake_s = cm_valid_r && cm_ready;
        sup_sum_s   = {1'b0, suppressed_r} + 17'(popcount8(suppress_s));
    end

    // Pending bitmap and occurrence counters; a same-edge event on the
    // selected type starts a fresh occurrence rather than joining the command.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_r <= 8'h00;
            for (int i = 0; i < THREAT_W; i++) begin
                occ_r[i] <= CNT_W'(0);
            end
        end else begin
            for (int i = 0; i < THREAT_W; i++) begin
                if (!enable || !mask[i]) begin
                    pending_r[i] <= 1'b0;
                    occ_r[i]     <= CNT_W'(0);
                end else if (accept_s[i]) begin
                    pending_r[i] <= 1'b1;
                    if (take_s && grant_s[i]) begin
                        occ_r[i] <= CNT_W'(1);
                    end else if (occ_r[i] == OCC_MAX) begin
                        occ_r[i] <= OCC_MAX;
                    end else begin
                        occ_r[i] <= occ_r[i] + CNT_W'(1);
                    end
                end else if (take_s && grant_s[i]) begin
                    pending_r[i] <= 1'b0;
                    occ_r[i]     <= CNT_W'(0);
                end else begin
                    pending_r[i] <= pending_r[i];
                    occ_r[i]     <= occ_r[i];
                end
            end
        end
    end

    // Cooldown counters: reload on handshake of that type, otherwise count down to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < THREAT_W; i++) begin
                cooldown_r[i] <= CD_W'(0);
            end
        end else begin
            for (int i = 0; i < THREAT_W; i++) begin
                if (handshake_s && (cm_id_r == 3'(i))) begin
                    cooldown_r[i] <= CD_LOAD;
                end else if (cool_s[i]) begin
                    cooldown_r[i] <= cooldown_r[i] - CD_W'(1);
                end else begin
                    cooldown_r[i] <= cooldown_r[i];
                end
            end
        end
    end

    // Saturating count of events dropped while their type was cooling down.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            suppressed_r <= 16'h0000;
        end else if (sup_sum_s[16]) begin
            suppressed_r <= 16'hFFFF;
        end else begin
            suppressed_r <= sup_sum_s[15:0];
        end
    end

    // Command FSM with registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            cm_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            cm_id_r    <= 3'd0;
            cm_count_r <= CNT_W'(0);
            rr_ptr_r   <= 3'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (take_s) begin
                        state_r    <= ISSUE;
                        cm_valid_r <= 1'b1;
                        busy_r     <= 1'b1;
                        cm_id_r    <= sel_s;
                        cm_count_r <= occ_r[sel_s];
                    end else begin
                        state_r    <= IDLE;
                    end
                end
                ISSUE: begin
                    if (cm_ready) begin
                        state_r    <= IDLE;
                        cm_valid_r <= 1'b0;
                        busy_r     <= 1'b0;
                        rr_ptr_r   <= cm_id_r + 3'd1;
                    end else begin
                        state_r    <= ISSUE;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    cm_valid_r <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    assign cm_valid       = cm_valid_r;
    assign busy           = busy_r;
    assign cm_id          = cm_id_r;
    assign cm_count       = cm_count_r;
    assign pending        = pending_r;
    assign suppressed_cnt = suppressed_r;

endmodule

// File: tb/tb_threat_response_scheduler.sv
// Directed bench for threat_response_scheduler with hand-computed expectations
// (HOLDOFF_CYCLES = 16, CNT_W = 4).
module tb_threat_response_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] threat_vector;
    logic       enable;
    logic [7:0] mask;
    logic       cm_valid;
    logic       cm_ready;
    logic [2:0] cm_id;
    logic [3:0] cm_count;
    logic [7:0] pending;
    logic       busy;
    logic [15:0] suppressed_cnt;

    int checks = 0;
    int errors = 0;

    threat_response_scheduler #(.HOLDOFF_CYCLES(16), .CNT_W(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .threat_vector  (threat_vector),
        .enable         (enable),
        .mask           (mask),
        .cm_valid       (cm_valid),
        .cm_ready       (cm_ready),
        .cm_id          (cm_id),
        .cm_count       (cm_count),
        .pending        (pending),
        .busy           (busy),
        .suppressed_cnt (suppressed_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cmd(input string tag, input logic [2:0] id, input logic [3:0] cnt);
        chk({tag, "_valid"}, 32'(cm_valid), 32'd1);
        chk({tag, "_busy"},  32'(busy),     32'd1);
        chk({tag, "_id"},    32'(cm_id),    32'(id));
        chk({tag, "_count"}, 32'(cm_count), 32'(cnt));
    endtask

    initial begin
        logic [7:0] exp_pend;
        reset = 1'b1; threat_vector = 8'h00; enable = 1'b1; mask = 8'hFF; cm_ready = 1'b0;
        tick();
        chk("rst_valid", 32'(cm_valid), 32'd0);
        chk("rst_id", 32'(cm_id), 32'd0);
        chk("rst_count", 32'(cm_count), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_supp", 32'(suppressed_cnt), 32'd0);
        reset = 1'b0;

        // Round-robin sweep from pointer 0
        cm_ready = 1'b1; threat_vector = 8'hFF;
        tick();
        chk("rr_pending", 32'(pending), 32'hFF);
        chk("rr_idle", 32'(cm_valid), 32'd0);
        threat_vector = 8'h00;
        for (int k = 0; k < 8; k++) begin
            tick();
            cmd("rr_cmd", 3'(k), 4'd1);
            exp_pend = 8'hFF << (k + 1);
            chk("rr_pend_left", 32'(pending), 32'(exp_pend));
            tick();
            chk("rr_gap", 32'(cm_valid), 32'd0);
        end
        repeat (20) tick();

        // Single event, two-edge latency
        threat_vector = 8'h08;
        tick();
        chk("single_pending", 32'(pending), 32'h08);
        chk("single_novalid", 32'(cm_valid), 32'd0);
        threat_vector = 8'h00;
        tick();
        cmd("single_cmd", 3'd3, 4'd1);
        chk("single_clr", 32'(pending), 32'h00);
        tick();
        chk("single_done", 32'(cm_valid), 32'd0);

        // Cooldown boundary: 16 samples dropped, the 17th accepted
        threat_vector = 8'h08;
        repeat (16) tick();
        chk("cd_supp16", 32'(suppressed_cnt), 32'd16);
        chk("cd_blocked", 32'(pending), 32'h00);
        tick();
        chk("cd_accept", 32'(pending), 32'h08);
        chk("cd_supp_hold", 32'(suppressed_cnt), 32'd16);
        threat_vector = 8'h00;
        tick();
        cmd("cd_cmd", 3'd3, 4'd1);
        tick();
        chk("cd_done", 32'(cm_valid), 32'd0);

        // Coalescing under backpressure
        cm_ready = 1'b0; threat_vector = 8'h01;
        repeat (5) tick();
        cmd("co_first", 3'd0, 4'd1);
        chk("co_pending", 32'(pending), 32'h01);
        threat_vector = 8'h00;
        repeat (2) tick();
        cmd("co_hold", 3'd0, 4'd1);
        cm_ready = 1'b1;
        tick();
        chk("co_hs", 32'(cm_valid), 32'd0);
        chk("co_pend_keep", 32'(pending), 32'h01);
        tick();
        cmd("co_second", 3'd0, 4'd4);
        tick();
        chk("co_done", 32'(cm_valid), 32'd0);

        // Occurrence saturation and mask flush
        cm_ready = 1'b0; threat_vector = 8'h02;
        tick();
        threat_vector = 8'h30;
        repeat (20) tick();
        cmd("sat_issue", 3'd1, 4'd1);
        chk("sat_pending", 32'(pending), 32'h30);
        threat_vector = 8'h00; mask = 8'h10;
        tick();
        chk("mask_flush", 32'(pending), 32'h10);
        mask = 8'hFF; cm_ready = 1'b1;
        tick();
        chk("sat_hs", 32'(cm_valid), 32'd0);
        cm_ready = 1'b0;
        tick();
        cmd("sat_cmd", 3'd4, 4'd15);

        // Enable drop during ISSUE
        threat_vector = 8'h04;
        tick();
        chk("en_pend_pre", 32'(pending), 32'h04);
        threat_vector = 8'h00; enable = 1'b0;
        tick();
        chk("en_flush", 32'(pending), 32'h00);
        cmd("en_inflight", 3'd4, 4'd15);
        cm_ready = 1'b1;
        tick();
        chk("en_hs", 32'(cm_valid), 32'd0);
        enable = 1'b1; cm_ready = 1'b0;
        tick();
        chk("en_quiet", 32'(cm_valid), 32'd0);

        // Reset while a command is in flight
        threat_vector = 8'h80;
        tick();
        threat_vector = 8'h20;
        tick();
        cmd("rs_issue", 3'd7, 4'd1);
        chk("rs_pend_pre", 32'(pending), 32'h20);
        threat_vector = 8'h00;
        reset = 1'b1;
        #1;
        chk("rs_valid", 32'(cm_valid), 32'd0);
        chk("rs_busy", 32'(busy), 32'd0);
        chk("rs_pending", 32'(pending), 32'd0);
        chk("rs_supp", 32'(suppressed_cnt), 32'd0);
        #1;
        reset = 1'b0;
        threat_vector = 8'h82;
        tick();
        chk("rs_pend_post", 32'(pending), 32'h82);
        threat_vector = 8'h00;
        tick();
        cmd("rs_ptr0", 3'd1, 4'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/threat_response_scheduler.md
# threat_response_scheduler

Sequences countermeasure commands from the 8-bit per-cycle threat vector produced by the signal monitor. Captures and coalesces threat events and arbitrates among pending threat types with round-robin priority. Issues one countermeasure command at a time over a valid/ready handshake to the jammer/response datapath. Enforces a per-threat cooldown after each serviced command so that a persistent threat cannot monopolise the responder.

## Interface
- HOLDOFF_CYCLES, 16: cooldown length per threat type after its command handshake; 0 disables cooldown
- CNT_W, 4: width of per-threat occurrence counter; saturates at 2^CNT_W-1
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- threat_vector  in  8  one bit per threat type, sampled every cycle; bit i set = event of type i this cycle
- enable  in  1  capture/arbitration enable
- mask  in  8  per-threat enable; 0 = type ignored
- cm_valid  out  1  command valid
- cm_ready  in  1  responder accepts command
- cm_id  out  3  threat type of command (0..7)
- cm_count  out  CNT_W  coalesced event count for cm_id, ≥1
- pending  out  8  registered pending bitmap
- busy  out  1  high in ISSUE state
- suppressed_cnt  out  16  events discarded due to cooldown, saturating at 0xFFFF

## Operation
- Event accept for bit i: threat_vector[i] & mask[i] & enable & (cooldown[i]==0). Accepted event sets pending[i] and increments occ[i] (saturating).
- Event discarded because only cooldown[i]!=0 (mask and enable high): suppressed_cnt += 1 per bit per cycle; multiple bits in one cycle add their popcount, saturating.
- mask[i]==0: pending[i] and occ[i] cleared next edge. enable==0: all pending/occ cleared next edge; an in-flight command is unaffected.
- FSM states IDLE, ISSUE.
  - IDLE: if pending (registered) nonzero, round-robin arbiter selects lowest index ≥ rr_ptr, wrapping 7→0. Next edge: cm_id←sel, cm_count←occ[sel], pending[sel]/occ[sel] cleared, state←ISSUE.
  - Same-edge event on sel: set wins; pending[sel]=1, occ[sel]=1 (new occurrence, not merged into latched command).
  - ISSUE: cm_valid=1, cm_id/cm_count held stable until cm_valid&cm_ready. On handshake edge: cooldown[sel]←HOLDOFF_CYCLES, rr_ptr←(sel+1) mod 8, state←IDLE.
- Events for the in-flight type during ISSUE accumulate in pending/occ (cooldown not yet active).
- Cooldown counters decrement by 1 per cycle to 0; an event is accepted in the first cycle its counter reads 0.
- busy = (state==ISSUE).

## Timing
- Reset values: cm_valid 0, cm_id 0, cm_count 0, pending 0, busy 0, suppressed_cnt 0, rr_ptr 0, all cooldown 0, state IDLE.
- Event at edge N visible in pending after N; cm_valid rises after edge N+1 (2-cycle latency from sampled event to valid).
- Handshake completes at edge where cm_valid&cm_ready; cm_valid low for ≥1 cycle (IDLE) before next command; back-to-back throughput one command per 2 cycles.
- cm_ready may be held high continuously; cm_ready while cm_valid low has no effect.
- HOLDOFF_CYCLES=H: after handshake at edge M, events of that type discarded through cycle M+H, accepted at M+H+1.
- Reset mid-ISSUE: cm_valid drops asynchronously; command lost, no cooldown applied.

## Structure
- Package ew_pkg: THREAT_W=8; threat_id_t enum BURST_JAM=0, SIGNAL_DROP, SPOOF, BLANKING, RAMP_JAM, ENTROPY_NOISE, RANDOM_NOISE, ALL_ZERO; sched_state_t {IDLE, ISSUE}.
- Sub-module rr_arbiter: 8-bit request, 3-bit pointer in; one-hot grant, 3-bit index, any_req out; purely combinational.
- Cooldown counters width $clog2(HOLDOFF_CYCLES+1), minimum 1.

## Test plan
- Single event: mask=0xFF, enable=1, threat_vector=0x08 for one cycle, cm_ready=1 → cm_valid one cycle, cm_id=3, cm_count=1, two cycles after sampling edge.
- Coalescing/backpressure: bit 0 asserted 5 cycles, cm_ready=0 → first command cm_id=0, cm_count=1 held stable; events after selection give pending[0]=1, occ=4; after ready, second command cm_count=4 (after cooldown expiry with H=0).
- Round-robin: threat_vector=0xFF one cycle, cm_ready=1, H=0 → cm_id sequence 0,1,2..7, one command per 2 cycles.
- Cooldown: H=16, bit 5 asserted continuously → commands 17 cycles apart after each handshake; suppressed_cnt increments 16 per cycle-window.
- Mask/enable flush: pending=0x30, mask→0x10 → pending=0x10 next cycle; enable→0 during ISSUE → command still completes, pending=0.
- Reset mid-ISSUE: assert reset with cm_valid=1 → cm_valid, pending, suppressed_cnt 0 immediately; first command after release uses rr_ptr=0.
